// File: rtl/fetch_inst_queue.sv
// Buffered fetch-to-decode instruction queue: accepts up to IN_LANES instructions
// per cycle, hands them to decode in program order one per cycle, single-cycle flush.
module fetch_inst_queue #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned IN_LANES = 2,
  localparam int unsigned IW      = $clog2(DEPTH),
  localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IN_LANES-1:0]          fs_to_iq_valid,
  input  logic [IN_LANES*DATA_W-1:0]   fs_to_iq_bus,
  output logic                         iq_allowin,
  input  logic                         flush,
  output logic                         iq_to_ds_valid,
  output logic [DATA_W-1:0]            iq_to_ds_bus,
  input  logic                         ds_allowin,
  output logic [CW-1:0]                count
);

  localparam int unsigned LW = $clog2(IN_LANES + 1);

  logic [CW-1:0]     head_r;
  logic [CW-1:0]     tail_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [CW-1:0]     count_s;
  logic [CW-1:0]     free_s;
  logic [LW-1:0]     lane_cnt_s;
  logic              run_s;
  logic              push_s;
  logic              pop_s;
  logic [IN_LANES-1:0] wr_en_s;
  logic [IW-1:0]     wr_idx_s [IN_LANES];

  // Occupancy and handshake flags; allowin looks at current occupancy only.
  always_comb begin
    count_s        = tail_r - head_r;
    free_s         = CW'(DEPTH) - count_s;
    iq_allowin     = (free_s >= CW'(IN_LANES));
    iq_to_ds_valid = (count_s != '0);
    iq_to_ds_bus   = mem_r[head_r[IW-1:0]];
    count          = count_s;
    pop_s          = iq_to_ds_valid && ds_allowin && !flush;
  end

  // Count the valid lanes contiguous from lane 0; a gap at lane 0 pushes nothing.
  always_comb begin
    lane_cnt_s = '0;
    run_s      = 1'b1;
    for (int i = 0; i < int'(IN_LANES); i++) begin
      if (run_s && fs_to_iq_valid[i]) begin
        lane_cnt_s = lane_cnt_s + LW'(1);
      end else begin
        run_s = 1'b0;
      end
    end
    push_s = iq_allowin && (lane_cnt_s != '0) && !flush;
    for (int i = 0; i < int'(IN_LANES); i++) begin
      wr_en_s[i]  = push_s && (LW'(i) < lane_cnt_s);
      wr_idx_s[i] = tail_r[IW-1:0] + IW'(i);
    end
  end

  // Entry storage, written lane by lane at consecutive tail slots.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(IN_LANES); i++) begin
        if (wr_en_s[i]) begin
          mem_r[wr_idx_s[i]] <= fs_to_iq_bus[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Head/tail pointers with wrap bit; flush overrides push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r <= '0;
      tail_r <= '0;
    end else if (flush) begin
      head_r <= '0;
      tail_r <= '0;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + CW'(lane_cnt_s);
      end
      if (pop_s) begin
        head_r <= head_r + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed self-checking bench for fetch_inst_queue (DEPTH=4, IN_LANES=2).
module tb_fetch_inst_queue;

  logic         clk;
  logic         reset;
  logic [1:0]   fs_to_iq_valid;
  logic [127:0] fs_to_iq_bus;
  logic         iq_allowin;
  logic         flush;
  logic         iq_to_ds_valid;
  logic [63:0]  iq_to_ds_bus;
  logic         ds_allowin;
  logic [2:0]   count;

  int checks;
  int errors;
  logic [31:0] exp_q [$];
  logic [31:0] pcn;
  logic        do_push;
  logic        do_pop;

  fetch_inst_queue #(.DATA_W(64), .DEPTH(4), .IN_LANES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .fs_to_iq_valid (fs_to_iq_valid),
    .fs_to_iq_bus   (fs_to_iq_bus),
    .iq_allowin     (iq_allowin),
    .flush          (flush),
    .iq_to_ds_valid (iq_to_ds_valid),
    .iq_to_ds_bus   (iq_to_ds_bus),
    .ds_allowin     (ds_allowin),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [31:0] pc);
    return {~pc, pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    fs_to_iq_valid = v;
    fs_to_iq_bus   = {mk(pc1), mk(pc0)};
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    flush = 1'b0;
    ds_allowin = 1'b0;
    offer(2'b00, 32'h0, 32'h0);
    #2;
    chk("rst_valid", 64'(iq_to_ds_valid), 64'd0);
    chk("rst_bus", iq_to_ds_bus, 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_allowin", 64'(iq_allowin), 64'd1);
    tick();
    tick();
    reset = 1'b1;

    // 1: two full groups fill the queue while decode stalls
    offer(2'b11, 32'h1c00_0000, 32'h1c00_0004);
    tick();
    chk("t1_count2", 64'(count), 64'd2);
    chk("t1_valid", 64'(iq_to_ds_valid), 64'd1);
    chk("t1_head", iq_to_ds_bus, mk(32'h1c00_0000));
    chk("t1_allowin2", 64'(iq_allowin), 64'd1);
    offer(2'b11, 32'h1c00_0008, 32'h1c00_000c);
    tick();
    offer(2'b00, 32'h0, 32'h0);
    chk("t1_count4", 64'(count), 64'd4);
    chk("t1_allowin4", 64'(iq_allowin), 64'd0);
    chk("t1_hold", iq_to_ds_bus, mk(32'h1c00_0000));

    // 2: drain in order
    ds_allowin = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_order", iq_to_ds_bus, mk(32'h1c00_0000 + 32'(4 * k)));
      tick();
      chk("t2_count", 64'(count), 64'(3 - k));
      chk("t2_allowin", 64'(iq_allowin), 64'((3 - k) <= 2));
    end
    chk("t2_valid", 64'(iq_to_ds_valid), 64'd0);

    // 3: streaming push/pop with scoreboard across many wraps
    pcn = 32'h1c00_1000;
    offer(2'b11, pcn, pcn + 32'd4);
    for (int c = 0; c < 20; c++) begin
      if (exp_q.size() != 0) chk("t3_head", iq_to_ds_bus, mk(exp_q[0]));
      chk("t3_allowin", 64'(iq_allowin), 64'((4 - exp_q.size()) >= 2));
      do_push = ((4 - exp_q.size()) >= 2);
      do_pop  = (exp_q.size() != 0);
      tick();
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(pcn);
        exp_q.push_back(pcn + 32'd4);
        pcn = pcn + 32'd8;
        offer(2'b11, pcn, pcn + 32'd4);
      end
      chk("t3_count", 64'(count), 64'(exp_q.size()));
    end
    chk("t3_range", 64'((count >= 3'd2) && (count <= 3'd4)), 64'd1);

    // 4: count=3, group refused while the pop proceeds
    offer(2'b00, 32'h0, 32'h0);
    ds_allowin = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_flush0", 64'(count), 64'd0);
    offer(2'b11, 32'h100, 32'h104);
    tick();
    offer(2'b01, 32'h108, 32'h0);
    tick();
    chk("t4_count3", 64'(count), 64'd3);
    chk("t4_head", iq_to_ds_bus, mk(32'h100));
    offer(2'b11, 32'h10c, 32'h110);
    ds_allowin = 1'b1;
    chk("t4_refuse", 64'(iq_allowin), 64'd0);
    tick();
    chk("t4_count2", 64'(count), 64'd2);
    chk("t4_head2", iq_to_ds_bus, mk(32'h104));

    // 5: flush beats a push and a pop in the same cycle
    ds_allowin = 1'b0;
    offer(2'b01, 32'h10c, 32'h0);
    tick();
    chk("t5_count3", 64'(count), 64'd3);
    flush = 1'b1;
    ds_allowin = 1'b1;
    offer(2'b11, 32'h200, 32'h204);
    tick();
    flush = 1'b0;
    ds_allowin = 1'b0;
    offer(2'b00, 32'h0, 32'h0);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_valid", 64'(iq_to_ds_valid), 64'd0);
    chk("t5_allowin", 64'(iq_allowin), 64'd1);
    offer(2'b01, 32'h300, 32'h0);
    tick();
    offer(2'b00, 32'h0, 32'h0);
    chk("t5_next", iq_to_ds_bus, mk(32'h300));
    chk("t5_count1", 64'(count), 64'd1);
    ds_allowin = 1'b1;
    tick();
    chk("t5_empty", 64'(iq_to_ds_valid), 64'd0);

    // 6: asynchronous reset mid-cycle, then an illegal 10 pattern
    ds_allowin = 1'b0;
    offer(2'b11, 32'h400, 32'h404);
    tick();
    offer(2'b00, 32'h0, 32'h0);
    chk("t6_count2", 64'(count), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_valid", 64'(iq_to_ds_valid), 64'd0);
    chk("t6_rst_bus", iq_to_ds_bus, 64'd0);
    chk("t6_rst_allowin", 64'(iq_allowin), 64'd1);
    #2;
    reset = 1'b1;
    offer(2'b10, 32'h0, 32'h500);
    tick();
    chk("t6_p10_count", 64'(count), 64'd0);
    tick();
    offer(2'b00, 32'h0, 32'h0);
    chk("t6_p10_count2", 64'(count), 64'd0);
    chk("t6_p10_valid", 64'(iq_to_ds_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
